// File: rtl/game_pkg.sv
// Shared choice encodings, referee state enum and round-judging helpers
// for the cat/dog/chicken game.
package game_pkg;

  localparam logic [2:0] CAT     = 3'b001;
  localparam logic [2:0] DOG     = 3'b010;
  localparam logic [2:0] CHICKEN = 3'b100;

  typedef enum logic [2:0] {
    S_P1,
    S_P2,
    S_JUDGE,
    S_SHOW,
    S_OVER
  } state_t;

  // One-hot choice to index: cat=0, dog=1, chicken=2 (non-one-hot maps to 0).
  function automatic logic [1:0] choice_idx(input logic [2:0] c);
    case (c)
      CAT:     return 2'd0;
      DOG:     return 2'd1;
      CHICKEN: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // True when index a defeats index b: dog>cat, cat>chicken, chicken>dog.
  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return ((a == 2'd1) && (b == 2'd0)) ||
           ((a == 2'd0) && (b == 2'd2)) ||
           ((a == 2'd2) && (b == 2'd1));
  endfunction

endpackage

// File: rtl/choice_decode.sv
// Validates a one-hot player choice and converts it to a 0..2 index.
module choice_decode
  import game_pkg::*;
(
  input  logic [2:0] choice_i,
  output logic       valid_o,
  output logic [1:0] idx_o
);

  assign valid_o = (choice_i == CAT) || (choice_i == DOG) || (choice_i == CHICKEN);
  assign idx_o   = choice_idx(choice_i);

endmodule

// File: rtl/round_referee.sv
// Two-player round referee: captures choices, judges rounds, keeps
// saturating scores and hands results to the draw controller via valid/ack.
module round_referee
  import game_pkg::*;
#(
  parameter int WIN_SCORE = 5,
  parameter int SCORE_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         p1_choice,
  input  logic [2:0]         p2_choice,
  input  logic               lock,
  input  logic               result_ack,
  output logic               result_valid,
  output logic [8:0]         scenario,
  output logic               winner1,
  output logic               winner2,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         awaiting,
  output logic               bad_choice,
  output logic               match_over
);

  localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(WIN_SCORE);

  logic       p1_ok, p2_ok;
  logic [1:0] p1_idx, p2_idx;

  choice_decode u_dec_p1 (.choice_i(p1_choice), .valid_o(p1_ok), .idx_o(p1_idx));
  choice_decode u_dec_p2 (.choice_i(p2_choice), .valid_o(p2_ok), .idx_o(p2_idx));

  state_t             state_q;
  logic [1:0]         c1_q, c2_q;
  logic [8:0]         scenario_q;
  logic               win1_q, win2_q, bad_q;
  logic [SCORE_W-1:0] score1_q, score2_q;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s >= WIN_S) ? WIN_S : s + 1'b1;
  endfunction

  logic [3:0] scen_idx_d;
  logic [8:0] scenario_d;
  logic       win1_d, win2_d;

  always_comb begin
    scen_idx_d = ({2'b00, c1_q} * 4'd3) + {2'b00, c2_q};
    scenario_d = 9'b1 << scen_idx_d;
    win1_d     = beats(c1_q, c2_q);
    win2_d     = beats(c2_q, c1_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_P1;
      c1_q       <= '0;
      c2_q       <= '0;
      scenario_q <= '0;
      win1_q     <= 1'b0;
      win2_q     <= 1'b0;
      bad_q      <= 1'b0;
      score1_q   <= '0;
      score2_q   <= '0;
    end else begin
      bad_q <= 1'b0;
      case (state_q)
        S_P1: if (lock) begin
          if (p1_ok) begin
            c1_q    <= p1_idx;
            state_q <= S_P2;
          end else begin
            bad_q <= 1'b1;
          end
        end
        S_P2: if (lock) begin
          if (p2_ok) begin
            c2_q    <= p2_idx;
            state_q <= S_JUDGE;
          end else begin
            bad_q <= 1'b1;
          end
        end
        S_JUDGE: begin
          scenario_q <= scenario_d;
          win1_q     <= win1_d;
          win2_q     <= win2_d;
          if (win1_d) score1_q <= sat_inc(score1_q);
          if (win2_d) score2_q <= sat_inc(score2_q);
          state_q    <= S_SHOW;
        end
        // Lock is deliberately not looked at here; ack alone leaves SHOW.
        S_SHOW: if (result_ack) begin
          state_q <= ((score1_q == WIN_S) || (score2_q == WIN_S)) ? S_OVER : S_P1;
        end
        S_OVER: if (lock) begin
          score1_q   <= '0;
          score2_q   <= '0;
          scenario_q <= '0;
          win1_q     <= 1'b0;
          win2_q     <= 1'b0;
          state_q    <= S_P1;
        end
        default: state_q <= S_P1;
      endcase
    end
  end

  assign result_valid = (state_q == S_SHOW);
  assign match_over   = (state_q == S_OVER);
  assign awaiting     = (state_q == S_P1) ? 2'b01 :
                        (state_q == S_P2) ? 2'b10 : 2'b00;
  assign scenario     = scenario_q;
  assign winner1      = win1_q;
  assign winner2      = win2_q;
  assign score1       = score1_q;
  assign score2       = score2_q;
  assign bad_choice   = bad_q;

endmodule

// File: tb/tb_round_referee.sv
// Scoreboard bench for round_referee: stimulus pushes expected results,
// a negedge monitor pops and compares when result_valid rises.
module tb_round_referee;

  localparam logic [2:0] T_CAT = 3'b001, T_DOG = 3'b010, T_CHK = 3'b100;

  logic       clk = 1'b0;
  logic       reset, lock, result_ack;
  logic [2:0] p1_choice, p2_choice;
  logic       result_valid, winner1, winner2, bad_choice, match_over;
  logic [8:0] scenario;
  logic [3:0] score1, score2;
  logic [1:0] awaiting;

  round_referee #(.WIN_SCORE(5), .SCORE_W(4)) dut (
    .clk(clk), .reset(reset), .p1_choice(p1_choice), .p2_choice(p2_choice),
    .lock(lock), .result_ack(result_ack), .result_valid(result_valid),
    .scenario(scenario), .winner1(winner1), .winner2(winner2),
    .score1(score1), .score2(score2), .awaiting(awaiting),
    .bad_choice(bad_choice), .match_over(match_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] scen;
    logic       w1, w2;
    logic [3:0] s1, s2;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic seen   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compare once per result presentation.
  always @(negedge clk) begin
    if (reset || !result_valid) begin
      seen = 1'b0;
    end else if (!seen) begin
      seen = 1'b1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0h required=none", scenario);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_scenario", 32'(scenario), 32'(e.scen));
        chk("sb_winner1",  32'(winner1),  32'(e.w1));
        chk("sb_winner2",  32'(winner2),  32'(e.w2));
        chk("sb_score1",   32'(score1),   32'(e.s1));
        chk("sb_score2",   32'(score2),   32'(e.s2));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lock1(input logic [2:0] c);
    p1_choice = c; lock = 1'b1; step(); lock = 1'b0;
  endtask

  task automatic lock2(input logic [2:0] c);
    p2_choice = c; lock = 1'b1; step(); lock = 1'b0;
  endtask

  task automatic issue(input logic [2:0] c1, input logic [2:0] c2, input logic [8:0] scen,
                       input logic w1, input logic w2, input logic [3:0] s1, input logic [3:0] s2);
    exp_t e;
    lock1(c1);
    chk("awaiting_p2", 32'(awaiting), 32'(2'b10));
    e.scen = scen; e.w1 = w1; e.w2 = w2; e.s1 = s1; e.s2 = s2;
    sb.push_back(e);
    lock2(c2);
    chk("judge_not_valid", 32'(result_valid), 32'd0);
    chk("judge_awaiting", 32'(awaiting), 32'd0);
    step();
    chk("latency_valid", 32'(result_valid), 32'd1);
  endtask

  task automatic ack();
    result_ack = 1'b1; step(); result_ack = 1'b0;
    chk("ack_drops_valid", 32'(result_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; lock = 1'b0; result_ack = 1'b0;
    p1_choice = 3'b000; p2_choice = 3'b000;
    step(); step();
    reset = 1'b0;
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_awaiting", 32'(awaiting), 32'(2'b01));
    chk("rst_scores", {score1, score2}, 32'd0);
    chk("rst_scenario", 32'(scenario), 32'd0);
    chk("rst_winners", {winner1, winner2}, 32'd0);
    chk("rst_bad", 32'(bad_choice), 32'd0);
    chk("rst_over", 32'(match_over), 32'd0);

    issue(T_DOG, T_CAT, 9'h008, 1'b1, 1'b0, 4'd1, 4'd0);
    ack();
    chk("after_ack_awaiting", 32'(awaiting), 32'(2'b01));
    issue(T_CHK, T_CHK, 9'h100, 1'b0, 1'b0, 4'd1, 4'd0);
    ack();

    lock1(3'b011);
    chk("bad_011_pulse", 32'(bad_choice), 32'd1);
    chk("bad_011_awaiting", 32'(awaiting), 32'(2'b01));
    step();
    chk("bad_011_clear", 32'(bad_choice), 32'd0);
    lock1(3'b000);
    chk("bad_000_pulse", 32'(bad_choice), 32'd1);
    chk("bad_000_awaiting", 32'(awaiting), 32'(2'b01));
    step();
    chk("bad_000_clear", 32'(bad_choice), 32'd0);

    // Bad P2 choice, then a valid one: cat vs dog, P2 wins.
    lock1(T_CAT);
    lock2(3'b110);
    chk("bad_p2_pulse", 32'(bad_choice), 32'd1);
    chk("bad_p2_awaiting", 32'(awaiting), 32'(2'b10));
    begin
      exp_t e;
      e.scen = 9'h002; e.w1 = 1'b0; e.w2 = 1'b1; e.s1 = 4'd1; e.s2 = 4'd1;
      sb.push_back(e);
    end
    lock2(T_DOG);
    step();
    chk("p2_round_valid", 32'(result_valid), 32'd1);
    ack();

    // Hold ack low for 20 cycles while pulsing lock.
    issue(T_CAT, T_CHK, 9'h004, 1'b1, 1'b0, 4'd2, 4'd1);
    for (int i = 0; i < 20; i++) begin
      p1_choice = T_DOG; p2_choice = T_DOG;
      lock = (i % 2 == 0);
      step();
      chk("hold_stable", {result_valid, scenario, winner1, winner2, score1, score2},
          {1'b1, 9'h004, 1'b1, 1'b0, 4'd2, 4'd1});
    end
    lock = 1'b1; result_ack = 1'b1;
    step();
    lock = 1'b0; result_ack = 1'b0;
    chk("ack_lock_valid", 32'(result_valid), 32'd0);
    chk("ack_lock_awaiting", 32'(awaiting), 32'(2'b01));
    step();
    chk("ack_lock_discarded", 32'(awaiting), 32'(2'b01));

    // P2 wins a full match from zero.
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst2_scores", {score1, score2}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      issue(T_CHK, T_CAT, 9'h040, 1'b0, 1'b1, 4'd0, 4'(k));
      ack();
      if (k < 5) begin
        chk("mid_match_over", 32'(match_over), 32'd0);
        chk("mid_match_awaiting", 32'(awaiting), 32'(2'b01));
      end else begin
        chk("match_over", 32'(match_over), 32'd1);
        chk("match_awaiting", 32'(awaiting), 32'd0);
        chk("match_score2", 32'(score2), 32'd5);
      end
    end
    step(); step();
    chk("over_held", {match_over, score2}, {1'b1, 4'd5});
    lock1(T_CAT);
    chk("clear_scores", {score1, score2}, 32'd0);
    chk("clear_awaiting", 32'(awaiting), 32'(2'b01));
    chk("clear_over", 32'(match_over), 32'd0);
    chk("clear_result", {scenario, winner1, winner2}, 32'd0);

    // Reset in the middle of a handshake with score1 = 3.
    issue(T_DOG, T_CAT, 9'h008, 1'b1, 1'b0, 4'd1, 4'd0);
    ack();
    issue(T_DOG, T_CAT, 9'h008, 1'b1, 1'b0, 4'd2, 4'd0);
    ack();
    issue(T_DOG, T_CAT, 9'h008, 1'b1, 1'b0, 4'd3, 4'd0);
    step();
    chk("pre_rst_score1", 32'(score1), 32'd3);
    reset = 1'b1; result_ack = 1'b0;
    step();
    reset = 1'b0;
    chk("show_rst_valid", 32'(result_valid), 32'd0);
    chk("show_rst_scores", {score1, score2}, 32'd0);
    chk("show_rst_awaiting", 32'(awaiting), 32'(2'b01));

    step(); step();
    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_referee.md
# round_referee

Two-player round referee sitting upstream of the game controller/datapath. It locks in each player's cat/dog/chicken choice from the shared switch bank, judges the round, and keeps per-player scores up to a match target. It then presents a registered one-hot scenario plus winner flags to the draw controller through a valid/ack handshake. The scores drive the HEX digit decoders directly.

## Interface
- `WIN_SCORE`, default 5: match target; a player reaching it ends the match.
- `SCORE_W`, default 4: score width; must satisfy WIN_SCORE < 2^SCORE_W.

- `clk` input 1: single clock (CLOCK_50 domain).
- `reset` input 1: synchronous, active-high reset.
- `p1_choice` input 3: player 1 one-hot choice; cat=001, dog=010, chicken=100.
- `p2_choice` input 3: player 2 one-hot choice; same encoding, may share the same switches.
- `lock` input 1: one-cycle pulse from a debounced, edge-detected key.
- `result_ack` input 1: draw controller has consumed the result.
- `result_valid` output 1: scenario and winner flags are valid.
- `scenario` output 9: one-hot; bit index = 3*i1 + i2, with cat=0, dog=1, chicken=2.
- `winner1`, `winner2` output 1 each: round winner; both 0 on a draw.
- `score1`, `score2` output SCORE_W each: current scores.
- `awaiting` output 2: 01 = waiting for P1, 10 = waiting for P2, 00 = otherwise.
- `bad_choice` output 1: one-cycle pulse when `lock` arrives with a non-one-hot choice.
- `match_over` output 1: high while the match is finished.

## Operation
- Rules: dog beats cat; cat beats chicken; chicken beats dog; equal choices draw.
- S_P1 (reset state): on `lock` with a valid `p1_choice`, capture it and go to S_P2. With an invalid choice, pulse `bad_choice` and stay.
- S_P2: same behaviour for `p2_choice`, then go to S_JUDGE.
- S_JUDGE, one cycle:
  - Register `scenario`, `winner1` and `winner2`.
  - Increment the winner's score, saturating at WIN_SCORE.
  - Go to S_SHOW.
- S_SHOW:
  - `result_valid` = 1, and outputs are held stable.
  - On `result_ack`, go to S_OVER if either score equals WIN_SCORE, otherwise go to S_P1.
- S_OVER: `match_over` = 1 and scores are held. On `lock`, clear both scores, `scenario` and winner flags, then go to S_P1.
- `lock` is ignored in S_JUDGE and S_SHOW.
- `result_ack` is ignored whenever `result_valid` is 0.
- `scenario`, `winner1` and `winner2` keep their last judged values until the next S_JUDGE or a match clear.

## Timing
- Reset values:
  - State S_P1 and captured choices 0.
  - `scenario`=0, `winner1`=`winner2`=0, scores 0.
  - `result_valid`=0, `bad_choice`=0, `match_over`=0, `awaiting`=01.
- `awaiting`, `result_valid` and `match_over` are decoded from the state register; all other outputs are registered.
- Lock edge in S_P2 at edge e0: state is S_JUDGE after e0. Results and scores update at e1, and `result_valid` = 1 after e1. Lock-to-valid latency is 2 cycles.
- Ack sampled high at edge ek while in S_SHOW: `result_valid` = 0 after ek. Minimum round-trip is 1 cycle if ack is held high.
- `bad_choice` is high exactly one cycle, in the cycle after the offending lock edge.
- `reset` has priority over every other input in any state, including mid-handshake. This drops `result_valid` and clears the scores at the next edge.
- `lock` and `result_ack` arriving in the same cycle in S_SHOW: ack is honoured and lock is discarded.

## Structure
- Shared `game_pkg` holds:
  - `CAT`/`DOG`/`CHICKEN` 3-bit constants.
  - The state enum (S_P1, S_P2, S_JUDGE, S_SHOW, S_OVER).
  - A `choice_idx` function (one-hot to 0..2) and a `beats(a,b)` function.
- One sub-module, `choice_decode`: takes a 3-bit choice and outputs `valid` (exactly one bit set) plus a 2-bit index. It is instantiated twice.
- The FSM, capture registers and score counters live in `round_referee`.

## Test plan
- Reset, then P1 locks dog (010) and P2 locks cat (001):
  - `result_valid` rises 2 cycles after the second lock.
  - `scenario` = 9'b000001000 (bit 3).
  - `winner1` = 1, `score1` = 1, `score2` = 0.
- Chicken vs chicken: `scenario` bit 8 set, both winner flags 0, scores unchanged.
- Lock with `p1_choice` = 011, then 000:
  - `bad_choice` pulses each time.
  - `awaiting` stays 01, with no state change.
- Hold `result_ack` = 0 for 20 cycles in S_SHOW while pulsing `lock`: outputs stay stable and the lock is ignored. Ack then returns the block to `awaiting` = 01.
- P2 wins 5 rounds (cat vs chicken with P1 = chicken, P2 = cat):
  - After the 5th ack, `match_over` = 1 and `score2` = 5.
  - A further lock clears both scores to 0 and sets `awaiting` = 01.
- Assert `reset` in S_SHOW with `score1` = 3: after one edge, `result_valid` = 0, scores 0, `awaiting` = 01.
